// File: rtl/seq_lock_pkg.sv
// Shared types and elaboration helpers for the serial combination lock.
// State encodings are fixed: IDLE=0, UNLOCK=1, LOCKOUT=2; encoding 3 is illegal and recovers to IDLE.
package seq_lock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_UNLOCK  = 2'd1,
    ST_LOCKOUT = 2'd2
  } lock_state_e;

  function automatic int unsigned max_u(input int unsigned x, input int unsigned y);
    return (x > y) ? x : y;
  endfunction

  // Bits needed to hold the values 0..n, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_lock_timer.sv
// Loadable down-counter shared by the UNLOCK and LOCKOUT states.
// done_o flags the last cycle of the loaded interval (count == 1).
module lock_timer #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/seq_lock.sv
// Serial combination lock: matches a qualified bit stream against a runtime-loadable code,
// pulses unlck for UNLOCK_CYC cycles on success and locks out for LOCKOUT_CYC after MAX_FAIL failures.
module seq_lock
  import seq_lock_pkg::*;
#(
  parameter int unsigned           CODE_LEN    = 5,
  parameter logic [CODE_LEN-1:0]   CODE_RST    = 5'b01011,
  parameter int unsigned           MAX_FAIL    = 3,
  parameter int unsigned           UNLOCK_CYC  = 4,
  parameter int unsigned           LOCKOUT_CYC = 16
) (
  input  logic                             clk,
  input  logic                             Reset,
  input  logic                             a,
  input  logic                             a_vld,
  input  logic                             code_ld,
  input  logic [CODE_LEN-1:0]              code_in,
  output logic                             unlck,
  output logic                             locked_out,
  output logic [$clog2(MAX_FAIL+1)-1:0]    fail_cnt
);

  localparam int unsigned IW = $clog2(CODE_LEN);
  localparam int unsigned FW = $clog2(MAX_FAIL + 1);
  localparam int unsigned TW = cnt_width(max_u(UNLOCK_CYC, LOCKOUT_CYC));
  localparam logic [IW-1:0] LAST_IDX = IW'(CODE_LEN - 1);

  lock_state_e           state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [FW-1:0]         fail_q, fail_d;
  logic [CODE_LEN-1:0]   code_q, code_d;
  logic                  unlck_q, unlck_d;
  logic                  locked_q, locked_d;

  logic                  exp_bit;
  logic [FW-1:0]         fail_inc;
  logic                  tmr_load;
  logic [TW-1:0]         tmr_val;
  logic                  tmr_dec;
  logic                  tmr_done;

  // The code is entered MSB first, so idx counts down from the top bit.
  assign exp_bit  = code_q[LAST_IDX - idx_q];
  assign fail_inc = (fail_q == FW'(MAX_FAIL)) ? fail_q : fail_q + 1'b1;

  lock_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .Reset      (Reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .done_o     (tmr_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (Reset) begin
      // NOTE: the code register is ordinary state, so it is reset like the rest;
      // a fresh reset must restore CODE_RST rather than keep a stale runtime code.
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      fail_q   <= '0;
      code_q   <= CODE_RST;
      unlck_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q  <= state_d;
      idx_q    <= idx_d;
      fail_q   <= fail_d;
      code_q   <= code_d;
      unlck_q  <= unlck_d;
      locked_q <= locked_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    fail_d   = fail_q;
    code_d   = code_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (code_ld) begin
          code_d = code_in;
          idx_d  = '0;
        end else if (a_vld) begin
          if (a == exp_bit) begin
            if (idx_q == LAST_IDX) begin
              state_d  = ST_UNLOCK;
              tmr_load = 1'b1;
              tmr_val  = TW'(UNLOCK_CYC);
              fail_d   = '0;
              idx_d    = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else if (idx_q != '0) begin
            fail_d = fail_inc;
            if (fail_inc == FW'(MAX_FAIL)) begin
              state_d  = ST_LOCKOUT;
              tmr_load = 1'b1;
              tmr_val  = TW'(LOCKOUT_CYC);
              idx_d    = '0;
            end else begin
              // The failing bit may itself start a new attempt.
              idx_d = (a == code_q[CODE_LEN-1]) ? IW'(1) : '0;
            end
          end
        end
      end

      ST_UNLOCK: begin
        tmr_dec = 1'b1;
        if (tmr_done) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      end

      ST_LOCKOUT: begin
        tmr_dec = 1'b1;
        if (tmr_done) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          fail_d  = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Output decode, taken from the next state so the output flops track state_q exactly.
  always_comb begin
    unlck_d  = (state_d == ST_UNLOCK);
    locked_d = (state_d == ST_LOCKOUT);
  end

  assign unlck      = unlck_q;
  assign locked_out = locked_q;
  assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_seq_lock.sv
// Self-checking bench for seq_lock: directed scenarios plus randomized traffic
// compared against a cycle-count model of the lock's rules.
module tb_seq_lock;

  localparam int          UNLOCK_CYC  = 4;
  localparam int          LOCKOUT_CYC = 16;
  localparam int          MAX_FAIL    = 3;
  localparam logic [4:0]  C_RST       = 5'b01011;
  localparam logic [4:0]  C_NEW       = 5'b11100;

  logic       clk;
  logic       Reset;
  logic       a;
  logic       a_vld;
  logic       code_ld;
  logic [4:0] code_in;
  logic       unlck;
  logic       locked_out;
  logic [1:0] fail_cnt;

  int n_checks;
  int n_errors;

  // Model state: matched-bit count, failures, remaining pulse lengths.
  logic [4:0] m_code;
  int         m_idx;
  int         m_fail;
  int         m_unl;
  int         m_lock;

  seq_lock #(
    .CODE_LEN    (5),
    .CODE_RST    (C_RST),
    .MAX_FAIL    (MAX_FAIL),
    .UNLOCK_CYC  (UNLOCK_CYC),
    .LOCKOUT_CYC (LOCKOUT_CYC)
  ) dut (
    .clk        (clk),
    .Reset      (Reset),
    .a          (a),
    .a_vld      (a_vld),
    .code_ld    (code_ld),
    .code_in    (code_in),
    .unlck      (unlck),
    .locked_out (locked_out),
    .fail_cnt   (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input logic a_v, input logic vld_v, input logic ld_v,
                            input logic [4:0] cin_v, input logic rst_v);
    if (rst_v) begin
      m_code = C_RST;
      m_idx  = 0;
      m_fail = 0;
      m_unl  = 0;
      m_lock = 0;
    end else if (m_unl > 0) begin
      m_unl--;
      if (m_unl == 0) m_idx = 0;
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) begin
        m_fail = 0;
        m_idx  = 0;
      end
    end else if (ld_v) begin
      m_code = cin_v;
      m_idx  = 0;
    end else if (vld_v) begin
      if (a_v == m_code[4 - m_idx]) begin
        if (m_idx == 4) begin
          m_unl  = UNLOCK_CYC;
          m_fail = 0;
          m_idx  = 0;
        end else begin
          m_idx++;
        end
      end else if (m_idx >= 1) begin
        m_fail = (m_fail + 1 > MAX_FAIL) ? MAX_FAIL : m_fail + 1;
        if (m_fail == MAX_FAIL) begin
          m_lock = LOCKOUT_CYC;
          m_idx  = 0;
        end else begin
          m_idx = (a_v == m_code[4]) ? 1 : 0;
        end
      end
    end
  endtask

  // One clock: apply inputs, advance model at the edge, settle 1 time unit after.
  task automatic drive(input logic a_v, input logic vld_v, input logic ld_v,
                       input logic [4:0] cin_v, input logic rst_v);
    a       = a_v;
    a_vld   = vld_v;
    code_ld = ld_v;
    code_in = cin_v;
    Reset   = rst_v;
    @(posedge clk);
    model_step(a_v, vld_v, ld_v, cin_v, rst_v);
    #1;
  endtask

  task automatic send_bit(input logic b);
    drive(b, 1'b1, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    n_checks++;
    if (unlck !== 1'b0) begin n_errors++; $display("FAIL reset_unlck: got %0b expected 0", unlck); end
    n_checks++;
    if (locked_out !== 1'b0) begin n_errors++; $display("FAIL reset_locked: got %0b expected 0", locked_out); end
    n_checks++;
    if (fail_cnt !== 2'd0) begin n_errors++; $display("FAIL reset_fail_cnt: got %0d expected 0", fail_cnt); end
  endtask

  task automatic test_unlock();
    for (int i = 4; i >= 0; i--) begin
      send_bit(C_RST[i]);
      if (i > 0) begin
        n_checks++;
        if (unlck !== 1'b0) begin n_errors++; $display("FAIL unlock_early bit%0d: got %0b expected 0", 4 - i, unlck); end
      end
    end
    n_checks++;
    if (unlck !== 1'b1) begin n_errors++; $display("FAIL unlock_rise: got %0b expected 1", unlck); end
    n_checks++;
    if (fail_cnt !== 2'd0) begin n_errors++; $display("FAIL unlock_fail_cnt: got %0d expected 0", fail_cnt); end
    for (int j = 0; j < UNLOCK_CYC; j++) begin
      idle();
      n_checks++;
      if (unlck !== (j < UNLOCK_CYC - 1)) begin
        n_errors++;
        $display("FAIL unlock_width cyc%0d: got %0b expected %0b", j + 2, unlck, (j < UNLOCK_CYC - 1));
      end
    end
  endtask

  task automatic test_fail_then_unlock();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    n_checks++;
    if (fail_cnt !== 2'd1) begin n_errors++; $display("FAIL fail_once: got %0d expected 1", fail_cnt); end
    for (int i = 4; i >= 0; i--) send_bit(C_RST[i]);
    n_checks++;
    if (unlck !== 1'b1) begin n_errors++; $display("FAIL unlock_after_fail: got %0b expected 1", unlck); end
    n_checks++;
    if (fail_cnt !== 2'd0) begin n_errors++; $display("FAIL fail_cleared: got %0d expected 0", fail_cnt); end
    repeat (UNLOCK_CYC) idle();
  endtask

  task automatic test_lockout();
    for (int att = 0; att < MAX_FAIL; att++) begin
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      n_checks++;
      if (fail_cnt !== 2'(att + 1)) begin
        n_errors++;
        $display("FAIL lockout_count att%0d: got %0d expected %0d", att, fail_cnt, att + 1);
      end
      n_checks++;
      if (locked_out !== (att == MAX_FAIL - 1)) begin
        n_errors++;
        $display("FAIL lockout_enter att%0d: got %0b expected %0b", att, locked_out, (att == MAX_FAIL - 1));
      end
    end
    // Correct code during lockout must be ignored.
    for (int i = 4; i >= 0; i--) begin
      send_bit(C_RST[i]);
      n_checks++;
      if (locked_out !== 1'b1 || unlck !== 1'b0) begin
        n_errors++;
        $display("FAIL lockout_ignore bit%0d: locked=%0b unlck=%0b expected 1/0", 4 - i, locked_out, unlck);
      end
    end
    // Six lockout cycles used so far; ten more remain.
    for (int j = 0; j <= LOCKOUT_CYC - 6; j++) begin
      idle();
      n_checks++;
      if (locked_out !== (j < LOCKOUT_CYC - 6)) begin
        n_errors++;
        $display("FAIL lockout_width cyc%0d: got %0b expected %0b", j + 7, locked_out, (j < LOCKOUT_CYC - 6));
      end
    end
    n_checks++;
    if (fail_cnt !== 2'd0) begin n_errors++; $display("FAIL lockout_exit_fail: got %0d expected 0", fail_cnt); end
    for (int i = 4; i >= 0; i--) send_bit(C_RST[i]);
    n_checks++;
    if (unlck !== 1'b1) begin n_errors++; $display("FAIL unlock_after_lockout: got %0b expected 1", unlck); end
    repeat (UNLOCK_CYC) idle();
  endtask

  task automatic test_code_load();
    drive(1'b0, 1'b0, 1'b1, C_NEW, 1'b0);
    for (int i = 4; i >= 0; i--) send_bit(C_NEW[i]);
    n_checks++;
    if (unlck !== 1'b1) begin n_errors++; $display("FAIL new_code_unlock: got %0b expected 1", unlck); end
    repeat (UNLOCK_CYC) idle();
    for (int i = 4; i >= 0; i--) begin
      send_bit(C_RST[i]);
      n_checks++;
      if (unlck !== 1'b0) begin n_errors++; $display("FAIL old_code_rejected bit%0d: got %0b expected 0", 4 - i, unlck); end
    end
    n_checks++;
    if (fail_cnt !== 2'd1) begin n_errors++; $display("FAIL old_code_fail_cnt: got %0d expected 1", fail_cnt); end
  endtask

  task automatic test_ld_and_vld();
    // Load wins; the simultaneous bit is dropped and idx restarts at 0.
    drive(1'b0, 1'b1, 1'b1, C_RST, 1'b0);
    for (int i = 4; i >= 1; i--) send_bit(C_RST[i]);
    n_checks++;
    if (fail_cnt !== 2'd1 || unlck !== 1'b0) begin
      n_errors++;
      $display("FAIL ld_vld_drop: fail=%0d unlck=%0b expected 1/0", fail_cnt, unlck);
    end
    send_bit(C_RST[0]);
    n_checks++;
    if (unlck !== 1'b1) begin n_errors++; $display("FAIL ld_vld_unlock: got %0b expected 1", unlck); end
    repeat (UNLOCK_CYC) idle();
  endtask

  task automatic test_reset_mid();
    for (int i = 4; i >= 0; i--) send_bit(C_RST[i]);
    idle();
    n_checks++;
    if (unlck !== 1'b1) begin n_errors++; $display("FAIL unlock_cycle2: got %0b expected 1", unlck); end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    n_checks++;
    if (unlck !== 1'b0 || locked_out !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_in_unlock: unlck=%0b locked=%0b expected 0/0", unlck, locked_out);
    end
    drive(1'b0, 1'b0, 1'b1, C_NEW, 1'b0);
    repeat (MAX_FAIL) begin
      send_bit(1'b1);
      send_bit(1'b0);
    end
    n_checks++;
    if (locked_out !== 1'b1) begin n_errors++; $display("FAIL lockout_new_code: got %0b expected 1", locked_out); end
    idle();
    idle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    n_checks++;
    if (locked_out !== 1'b0 || fail_cnt !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_in_lockout: locked=%0b fail=%0d expected 0/0", locked_out, fail_cnt);
    end
    for (int i = 4; i >= 0; i--) send_bit(C_RST[i]);
    n_checks++;
    if (unlck !== 1'b1) begin n_errors++; $display("FAIL code_restored: got %0b expected 1", unlck); end
    repeat (UNLOCK_CYC) idle();
  endtask

  task automatic test_random();
    logic       r_a, r_vld, r_ld, r_rst;
    logic [4:0] r_cin;
    for (int n = 0; n < 4000; n++) begin
      r_vld = ($urandom_range(0, 9) < 7);
      r_ld  = ($urandom_range(0, 99) < 3);
      r_rst = ($urandom_range(0, 199) == 0);
      r_cin = ($urandom_range(0, 1) == 0) ? C_RST : 5'($urandom);
      // Bias toward the expected bit so unlocks actually happen.
      if (m_unl == 0 && m_lock == 0 && $urandom_range(0, 99) < 85) r_a = m_code[4 - m_idx];
      else r_a = 1'($urandom);
      drive(r_a, r_vld, r_ld, r_cin, r_rst);
      n_checks++;
      if (unlck !== (m_unl > 0)) begin
        n_errors++;
        $display("FAIL rand_unlck cyc%0d: got %0b expected %0b", n, unlck, (m_unl > 0));
      end
      n_checks++;
      if (locked_out !== (m_lock > 0)) begin
        n_errors++;
        $display("FAIL rand_locked cyc%0d: got %0b expected %0b", n, locked_out, (m_lock > 0));
      end
      n_checks++;
      if (fail_cnt !== 2'(m_fail)) begin
        n_errors++;
        $display("FAIL rand_fail_cnt cyc%0d: got %0d expected %0d", n, fail_cnt, m_fail);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_code   = C_RST;
    m_idx    = 0;
    m_fail   = 0;
    m_unl    = 0;
    m_lock   = 0;
    Reset    = 1'b1;
    a        = 1'b0;
    a_vld    = 1'b0;
    code_ld  = 1'b0;
    code_in  = 5'd0;

    test_reset();
    test_unlock();
    test_fail_then_unlock();
    test_lockout();
    test_code_load();
    test_ld_and_vld();
    test_reset_mid();
    test_random();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
